// File: rtl/phase_measure_pkg.sv
// Shared definitions for the 1PPS phase measurement block.
package phase_measure_pkg;

    localparam int PHASE_W    = 24;
    localparam int CLK_HZ_DEF = 10_000_000;

    localparam logic [PHASE_W-1:0] PHASE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Increment that sticks at the top of the phase range.
    function automatic logic [PHASE_W-1:0] sat_inc(input logic [PHASE_W-1:0] v);
        return (v == PHASE_MAX) ? v : v + PHASE_W'(1);
    endfunction

endpackage

// File: rtl/phase_measure_if.sv
// GPS pin, alignment request, local PPS and the Measure_Phase/Measure_Done
// hand-off to the PID loop. master = phase_measure, slave = consumer side.
interface phase_measure_if;
    import phase_measure_pkg::*;

    logic               PPS_Gps;
    logic               Align_Req;
    logic               PPS_Local;
    logic [PHASE_W-1:0] Measure_Phase;
    logic               Measure_Done;
    logic               Gps_Lost;

    modport master (
        input  PPS_Gps, Align_Req,
        output PPS_Local, Measure_Phase, Measure_Done, Gps_Lost
    );

    modport slave (
        output PPS_Gps, Align_Req,
        input  PPS_Local, Measure_Phase, Measure_Done, Gps_Lost
    );

endinterface

// File: rtl/phase_measure_pps_sync.sv
// Synchronizer plus rising-edge detector for an asynchronous pulse input.
// evt_o is a one-cycle pulse visible SYNC_STAGES cycles after the pin edge,
// acted upon at the following clock edge. SYNC_STAGES must be at least 2.
module pps_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Chain resets to ones so a pin already high at reset release is not
    // mistaken for a fresh edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/phase_measure.sv
// Local 1PPS generator and GPS-to-local phase measurement. Both the GPS
// edge and the local wrap see SYNC_STAGES+1 cycles of latency, so the
// measured count equals the pin-to-wrap distance in CLK_SYS cycles.
module phase_measure
    import phase_measure_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEF,
    parameter int PPS_WIDTH   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK_SYS,
    input  logic            CLK_RST,
    phase_measure_if.master bus
);

    localparam logic [PHASE_W-1:0] DIV_TC    = PHASE_W'(CLK_HZ - 1);
    localparam logic [PHASE_W-1:0] DIV_ALIGN = PHASE_W'(SYNC_STAGES + 1);
    localparam logic [PHASE_W-1:0] PPS_W     = PHASE_W'(PPS_WIDTH);
    localparam logic [24:0]        WD_LOST   = 25'(2 * CLK_HZ);

    logic               gps_evt, loc_evt, wrap_evt, align_load;
    logic               align_done_q;
    logic [PHASE_W-1:0] div_q, div_d;
    logic               pps_q;
    logic [SYNC_STAGES:0] loc_pipe_q;
    state_t             state_q, state_d;
    logic [PHASE_W-1:0] cnt_q, cnt_d, phase_q, phase_d, start_cnt;
    logic               pend_q, pend_d, done_q;
    logic [24:0]        wd_q, wd_d;
    logic               lost_q, lost_d;

    pps_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gps_sync (
        .clk_i   (CLK_SYS),
        .rst_ni  (CLK_RST),
        .async_i (bus.PPS_Gps),
        .evt_o   (gps_evt)
    );

    // The first GPS edge of each Align_Req high level re-zeroes the divider.
    assign align_load = gps_evt & bus.Align_Req & ~align_done_q;
    assign wrap_evt   = (div_q == DIV_TC) & ~align_load;
    assign loc_evt    = loc_pipe_q[SYNC_STAGES];

    // Divider next state; an alignment preloads the synchronizer latency.
    always_comb begin
        div_d = (div_q == DIV_TC) ? '0 : div_q + PHASE_W'(1);
        if (align_load) div_d = DIV_ALIGN;
    end

    // Divider, local PPS, wrap delay line and alignment one-shot.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            div_q        <= '0;
            pps_q        <= 1'b0;
            loc_pipe_q   <= '0;
            align_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            pps_q        <= (div_d < PPS_W);
            loc_pipe_q   <= {loc_pipe_q[SYNC_STAGES-1:0], wrap_evt};
            align_done_q <= bus.Align_Req & (align_done_q | align_load);
        end
    end

    // Measurement FSM next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        pend_d    = pend_q;
        start_cnt = '0;
        case (state_q)
            IDLE: begin
                if (gps_evt || pend_q) begin
                    // A deferred edge is already one cycle old when it starts.
                    start_cnt = gps_evt ? '0 : PHASE_W'(1);
                    pend_d    = 1'b0;
                    if (loc_evt) begin
                        phase_d = start_cnt;
                        state_d = REPORT;
                    end else begin
                        cnt_d   = start_cnt;
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                cnt_d = sat_inc(cnt_q);
                if (loc_evt) begin
                    phase_d = cnt_d;
                    state_d = REPORT;
                    if (gps_evt) pend_d = 1'b1;
                end else if (gps_evt) begin
                    cnt_d = '0;
                end else if (cnt_d == PHASE_MAX) begin
                    phase_d = PHASE_MAX;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (gps_evt) pend_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Alignment abandons whatever measurement was running.
        if (align_load) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            phase_d = phase_q;
        end
    end

    // Measurement FSM registers; Done trails the phase write by one cycle.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            done_q  <= (state_q == REPORT);
        end
    end

    // Watchdog next state: counts cycles since the last GPS edge.
    always_comb begin
        wd_d   = gps_evt ? '0 : ((wd_q == WD_LOST) ? wd_q : wd_q + 25'd1);
        lost_d = gps_evt ? 1'b0 : (lost_q | (wd_d == WD_LOST));
    end

    // Watchdog registers; GPS is presumed lost until the first edge.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            wd_q   <= '0;
            lost_q <= 1'b1;
        end else begin
            wd_q   <= wd_d;
            lost_q <= lost_d;
        end
    end

    assign bus.PPS_Local     = pps_q;
    assign bus.Measure_Phase = phase_q;
    assign bus.Measure_Done  = done_q;
    assign bus.Gps_Lost      = lost_q;

endmodule

// File: tb/tb_phase_measure.sv
// Directed + randomized bench for phase_measure with CLK_HZ=1000, PPS_WIDTH=100.
// Reference: the local second starts at cycle wb (+k*HZ); a pin edge driven just
// after edge P measures (wb-P) mod HZ, reported with Done SYNC_STAGES+2 edges
// after the local wrap.
module tb_phase_measure;
    import phase_measure_pkg::*;

    localparam int HZ  = 1000;
    localparam int PW  = 100;
    localparam int LAT = 4;     // wrap edge to sampled Done rise

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    phase_measure_if bus ();

    phase_measure #(.CLK_HZ(HZ), .PPS_WIDTH(PW), .SYNC_STAGES(2)) dut (
        .CLK_SYS (clk),
        .CLK_RST (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int now = 0, wb = 0, done_cnt = 0;
    int p_last, d0, p1, p2, nw;

    always @(negedge clk) if (bus.Measure_Done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        now++;
    endtask

    function automatic int mod_hz(input int v);
        return ((v % HZ) + HZ) % HZ;
    endfunction

    function automatic logic exp_pps(input int t);
        return mod_hz(t - wb) < PW;
    endfunction

    // Free-run n cycles comparing PPS_Local (and optionally Gps_Lost) every cycle.
    task automatic run_pps(input int n, input bit do_lost, input logic lost_exp, input string tag);
        int bad_pps = 0;
        int bad_lost = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.PPS_Local !== exp_pps(now)) bad_pps++;
            if (do_lost && bus.Gps_Lost !== lost_exp) bad_lost++;
        end
        chk({tag, "_pps_bad_cycles"}, bad_pps, 0);
        if (do_lost) chk({tag, "_lost_bad_cycles"}, bad_lost, 0);
    endtask

    // Drive a GPS pulse now and check the resulting report against the model.
    task automatic gps_measure(input string tag, output int p);
        int exp, rise, d_start;
        logic [PHASE_W-1:0] prev_ph;
        p       = now;
        exp     = mod_hz(wb - p);
        rise    = -1;
        d_start = done_cnt;
        prev_ph = bus.Measure_Phase;
        bus.PPS_Gps = 1'b1;
        for (int k = 0; k < HZ + 20 && rise < 0; k++) begin
            prev_ph = bus.Measure_Phase;
            tick();
            if (now == p + 10) bus.PPS_Gps = 1'b0;
            if (bus.Measure_Done === 1'b1) rise = now;
        end
        chk({tag, "_done_cycle"}, rise, p + exp + LAT);
        chk({tag, "_phase"}, bus.Measure_Phase, exp);
        chk({tag, "_phase_before_done"}, prev_ph, exp);
        tick();
        chk({tag, "_done_width"}, bus.Measure_Done, 1'b0);
        while (now < p + 10) tick();
        bus.PPS_Gps = 1'b0;
        chk({tag, "_done_count"}, done_cnt - d_start, 1);
    endtask

    initial begin
        bus.PPS_Gps   = 1'b0;
        bus.Align_Req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pps", bus.PPS_Local, 1'b0);
        chk("rst_phase", bus.Measure_Phase, 0);
        chk("rst_done", bus.Measure_Done, 1'b0);
        chk("rst_lost", bus.Gps_Lost, 1'b1);
        rst_n = 1'b1;
        now = 0;
        wb  = 0;

        // Free run, no GPS
        run_pps(2500, 1'b1, 1'b1, "t1");
        chk("t1_no_done", done_cnt, 0);

        // Pin 250 cycles ahead of the wrap at 3000
        while (now < 3000 - 250) tick();
        gps_measure("t2", p_last);
        chk("t2_lost_cleared", bus.Gps_Lost, 1'b0);

        // Pin coincident with the wrap at 4000
        while (now < 4000) tick();
        gps_measure("t3", p_last);

        // Random phases
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(800, 20)) tick();
            gps_measure("rnd", p_last);
        end

        // Two edges 50 apart, wrap 300 after the second: newer one wins
        nw = now + mod_hz(wb - now);
        if (nw - 350 < now + 20) nw += HZ;
        p1 = nw - 350;
        while (now < p1) tick();
        d0 = done_cnt;
        bus.PPS_Gps = 1'b1;
        repeat (10) tick();
        bus.PPS_Gps = 1'b0;
        while (now < p1 + 50) tick();
        gps_measure("t5", p_last);
        chk("t5_single_done", done_cnt - d0, 1);

        // Alignment aborts the running measurement and re-zeroes the divider
        nw = now + mod_hz(wb - now);
        if (nw - 600 < now + 20) nw += HZ;
        p1 = nw - 600;
        while (now < p1) tick();
        d0 = done_cnt;
        bus.PPS_Gps = 1'b1;
        repeat (10) tick();
        bus.PPS_Gps = 1'b0;
        while (now < p1 + 100) tick();
        p2 = now;
        bus.Align_Req = 1'b1;
        bus.PPS_Gps   = 1'b1;
        repeat (10) tick();
        bus.PPS_Gps = 1'b0;
        wb = p2;
        while (now < p2 + HZ - 1) tick();
        chk("t4_pps_before", bus.PPS_Local, 1'b0);
        tick();
        chk("t4_pps_rise", bus.PPS_Local, 1'b1);
        chk("t4_abort_no_done", done_cnt - d0, 0);
        // Align_Req still high: this edge must be measured, not realigned
        gps_measure("t4_meas", p_last);
        bus.Align_Req = 1'b0;

        // GPS silence: holdover and loss flag
        run_pps(p_last + 2002 - now, 1'b1, 1'b0, "t6_hold");
        tick();
        chk("t6_lost_set", bus.Gps_Lost, 1'b1);
        run_pps(500, 1'b1, 1'b1, "t6_lost");
        if (mod_hz(wb - now) == 0) tick();
        gps_measure("t6_meas", p_last);
        chk("t6_lost_cleared", bus.Gps_Lost, 1'b0);

        // Asynchronous reset in the middle of a measurement
        repeat ($urandom_range(300, 20)) tick();
        bus.PPS_Gps = 1'b1;
        repeat (50) tick();
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pps", bus.PPS_Local, 1'b0);
        chk("mid_rst_phase", bus.Measure_Phase, 0);
        chk("mid_rst_done", bus.Measure_Done, 1'b0);
        chk("mid_rst_lost", bus.Gps_Lost, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        now = 0;
        wb  = 0;
        repeat (5) tick();
        bus.PPS_Gps = 1'b0;
        run_pps(1500, 1'b1, 1'b1, "post_rst");
        chk("post_rst_no_done", done_cnt - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
